// File: rtl/cp0_exception_unit_pkg.sv
// -----------------------------------------------------------------------------
// cp0_exception_unit_pkg
//   Shared constants for the CP0 exception unit: CP0 register numbers,
//   exception codes, Status/Cause bit positions and FSM state encodings.
//   Header layout follows Para.v so the register file and this unit agree
//   on the numeric codes.
// -----------------------------------------------------------------------------
package cp0_exception_unit_pkg;

  // CP0 register numbers
  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  // Exception codes (Cause.ExcCode / EXCCODE)
  localparam logic [4:0] EXC_INT     = 5'h00;
  localparam logic [4:0] EXC_BREAK   = 5'h01;
  localparam logic [4:0] EXC_SYSCALL = 5'h03;
  localparam logic [4:0] EXC_OV      = 5'h0C;
  localparam logic [4:0] EXC_UNDEF   = 5'h1F;

  // Status bit positions
  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 8;
  localparam int ST_IM_HI = 15;

  // Cause bit positions
  localparam int CA_BD     = 31;
  localparam int CA_IP7    = 15;
  localparam int CA_IP_LO  = 8;
  localparam int CA_IP_HI  = 9;

  // FSM state encodings
  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_FLUSH      = 2'd1;
  localparam logic [1:0] S_REDIRECT   = 2'd2;
  localparam logic [1:0] S_ERET_REDIR = 2'd3;

  // Assemble the architectural Cause word from its stored fields.
  function automatic logic [31:0] pack_cause(input logic       bd,
                                             input logic       ip7,
                                             input logic [1:0] ip_sw,
                                             input logic [4:0] exc_code);
    logic [31:0] w;
    w = 32'd0;
    w[CA_BD]              = bd;
    w[CA_IP7]             = ip7;
    w[CA_IP_HI:CA_IP_LO]  = ip_sw;
    w[6:2]                = exc_code;
    return w;
  endfunction

  // Assemble the architectural Status word; unimplemented bits read 0.
  function automatic logic [31:0] pack_status(input logic       ie,
                                              input logic       exl,
                                              input logic [7:0] im);
    logic [31:0] w;
    w = 32'd0;
    w[ST_IE]              = ie;
    w[ST_EXL]             = exl;
    w[ST_IM_HI:ST_IM_LO]  = im;
    return w;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// -----------------------------------------------------------------------------
// cp0_timer
//   CP0 Count/Compare pair and timer interrupt bit (Cause.IP7).
//   Count increments every cycle and wraps; a Compare write clears IP7;
//   IP7 sets when Count == Compare with Compare non-zero.
//   Next-state values are exported so mfc0 reads can return them.
// Ports
//   Clock           rising-edge clock
//   Reset           synchronous active-low reset
//   count_wen_i     mtc0 to Count
//   compare_wen_i   mtc0 to Compare
//   wdata_i         mtc0 data
//   count_next_o    Count value after this edge
//   compare_next_o  Compare value after this edge
//   ip7_o           registered IP7
//   ip7_next_o      IP7 value after this edge
// -----------------------------------------------------------------------------
module cp0_timer
  import cp0_exception_unit_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        count_wen_i,
  input  logic        compare_wen_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_next_o,
  output logic [31:0] compare_next_o,
  output logic        ip7_o,
  output logic        ip7_next_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ip7_q, ip7_d;

  always_comb begin
    count_d   = count_wen_i ? wdata_i : count_q + 32'd1;
    compare_d = compare_wen_i ? wdata_i : compare_q;
    ip7_d     = ip7_q;
    // Compare write acknowledges the timer interrupt and wins over a match.
    if (compare_wen_i) begin
      ip7_d = 1'b0;
    end else if ((count_q == compare_q) && (compare_q != 32'd0)) begin
      ip7_d = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      ip7_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ip7_q     <= ip7_d;
    end
  end

  assign count_next_o   = count_d;
  assign compare_next_o = compare_d;
  assign ip7_o          = ip7_q;
  assign ip7_next_o     = ip7_d;

endmodule

// File: rtl/cp0_exception_unit.sv
// -----------------------------------------------------------------------------
// cp0_exception_unit
//   Arbitrates MEM-stage exceptions, eret and pending interrupts; keeps CP0
//   Status/Cause/EPC (Count/Compare in cp0_timer); drives flush and PC
//   redirect; serves mfc0/mtc0.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | ready to accept exception / eret / interrupt
//   FLUSH      | event committed, pipeline flushed for one cycle
//   REDIRECT   | flush + redirect to EXC_VECTOR
//   ERET_REDIR | flush + redirect to EPC
//
// Ports
//   Clock, Reset            clock, synchronous active-low reset
//   exc_valid/exc_ready     exception handshake (eret shares exc_ready)
//   exc_code_in, OPC        code and PC of the MEM-stage instruction
//   in_delay_slot, eret     MEM-stage qualifiers
//   cp0_wen/addr/wdata      mtc0 port; cp0_addr also selects mfc0 reads
//   cp0_rdata               registered mfc0 data
//   EXCCODE                 committed code, one cycle, 0 otherwise
//   flush, redirect_valid,
//   redirect_pc             pipeline control
//   exl, exc_count          Status.EXL, saturating accepted-event count
// -----------------------------------------------------------------------------
module cp0_exception_unit
  import cp0_exception_unit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
  parameter int          CNT_W      = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             exc_valid,
  output logic             exc_ready,
  input  logic [4:0]       exc_code_in,
  input  logic [31:0]      OPC,
  input  logic             in_delay_slot,
  input  logic             eret,
  input  logic             cp0_wen,
  input  logic [4:0]       cp0_addr,
  input  logic [31:0]      cp0_wdata,
  output logic [31:0]      cp0_rdata,
  output logic [4:0]       EXCCODE,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             exl,
  output logic [CNT_W-1:0] exc_count
);

  logic [1:0]       state_q, state_d;
  logic             ie_q, ie_d;
  logic             exl_q, exl_d;
  logic [7:0]       im_q, im_d;
  logic             bd_q, bd_d;
  logic [1:0]       ipsw_q, ipsw_d;
  logic [4:0]       cause_code_q, cause_code_d;
  logic [31:0]      epc_q, epc_d;
  logic [4:0]       excode_q, excode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;

  logic        idle;
  logic        int_pending;
  logic        take_exc, take_eret, take_int, take_trap;
  logic [4:0]  trap_code;
  logic        mtc0_ok;
  logic [31:0] count_next, compare_next;
  logic        ip7, ip7_next;

  assign idle        = (state_q == S_IDLE);
  assign int_pending = ie_q && !exl_q && |({ip7, 5'b0, ipsw_q} & im_q);

  // Exception beats eret beats interrupt.
  assign take_exc  = idle && exc_valid;
  assign take_eret = idle && eret && !exc_valid;
  assign take_int  = idle && !exc_valid && !eret && int_pending;
  assign take_trap = take_exc || take_int;
  assign trap_code = take_exc ? exc_code_in : EXC_INT;

  // Any taken event kills the MEM-stage instruction, so its mtc0 must not
  // commit; it is re-executed after return if it was the victim.
  assign mtc0_ok = cp0_wen && !(take_trap || take_eret);

  cp0_timer u_timer (
    .Clock          (Clock),
    .Reset          (Reset),
    .count_wen_i    (mtc0_ok && (cp0_addr == CP0_COUNT)),
    .compare_wen_i  (mtc0_ok && (cp0_addr == CP0_COMPARE)),
    .wdata_i        (cp0_wdata),
    .count_next_o   (count_next),
    .compare_next_o (compare_next),
    .ip7_o          (ip7),
    .ip7_next_o     (ip7_next)
  );

  always_comb begin
    state_d      = state_q;
    ie_d         = ie_q;
    exl_d        = exl_q;
    im_d         = im_q;
    bd_d         = bd_q;
    ipsw_d       = ipsw_q;
    cause_code_d = cause_code_q;
    epc_d        = epc_q;
    excode_d     = EXC_INT;
    cnt_d        = cnt_q;

    if (mtc0_ok) begin
      case (cp0_addr)
        CP0_STATUS: begin
          ie_d  = cp0_wdata[ST_IE];
          exl_d = cp0_wdata[ST_EXL];
          im_d  = cp0_wdata[ST_IM_HI:ST_IM_LO];
        end
        CP0_CAUSE: ipsw_d = cp0_wdata[CA_IP_HI:CA_IP_LO];
        CP0_EPC:   epc_d  = cp0_wdata;
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (take_trap) begin
          cause_code_d = trap_code;
          // Nested events keep the original return point.
          if (!exl_q) begin
            epc_d = in_delay_slot ? (OPC - 32'd4) : OPC;
            bd_d  = in_delay_slot;
          end
          exl_d    = 1'b1;
          cnt_d    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          excode_d = trap_code;
          state_d  = S_FLUSH;
        end else if (take_eret) begin
          exl_d   = 1'b0;
          state_d = S_ERET_REDIR;
        end
      end
      S_FLUSH:      state_d = S_REDIRECT;
      S_REDIRECT:   state_d = S_IDLE;
      S_ERET_REDIR: state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // mfc0 reads next-state values: same-cycle mtc0 and post-increment Count
  // are visible with one cycle of latency.
  always_comb begin
    case (cp0_addr)
      CP0_COUNT:   rdata_d = count_next;
      CP0_COMPARE: rdata_d = compare_next;
      CP0_STATUS:  rdata_d = pack_status(ie_d, exl_d, im_d);
      CP0_CAUSE:   rdata_d = pack_cause(bd_d, ip7_next, ipsw_d, cause_code_d);
      CP0_EPC:     rdata_d = epc_d;
      default:     rdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q      <= S_IDLE;
      ie_q         <= 1'b0;
      exl_q        <= 1'b0;
      im_q         <= 8'd0;
      bd_q         <= 1'b0;
      ipsw_q       <= 2'd0;
      cause_code_q <= 5'd0;
      epc_q        <= 32'd0;
      excode_q     <= 5'd0;
      cnt_q        <= '0;
      rdata_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      ie_q         <= ie_d;
      exl_q        <= exl_d;
      im_q         <= im_d;
      bd_q         <= bd_d;
      ipsw_q       <= ipsw_d;
      cause_code_q <= cause_code_d;
      epc_q        <= epc_d;
      excode_q     <= excode_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
    end
  end

  assign exc_ready      = idle;
  assign flush          = !idle;
  assign redirect_valid = (state_q == S_REDIRECT) || (state_q == S_ERET_REDIR);
  assign redirect_pc    = (state_q == S_REDIRECT)   ? EXC_VECTOR :
                          (state_q == S_ERET_REDIR) ? epc_q      : 32'd0;
  assign EXCCODE        = excode_q;
  assign exl            = exl_q;
  assign exc_count      = cnt_q;
  assign cp0_rdata      = rdata_q;

endmodule

// File: tb/tb_cp0_exception_unit.sv
module tb_cp0_exception_unit;

  localparam logic [31:0] VEC = 32'h8000_0180;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        exc_valid;
  logic        exc_ready;
  logic [4:0]  exc_code_in;
  logic [31:0] OPC;
  logic        in_delay_slot;
  logic        eret;
  logic        cp0_wen;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [4:0]  EXCCODE;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        exl;
  logic [15:0] exc_count;

  int checks = 0;
  int errors = 0;
  int edges  = 0;
  logic [31:0] exp_q[$];

  cp0_exception_unit dut (
    .Clock(Clock), .Reset(Reset), .exc_valid(exc_valid), .exc_ready(exc_ready),
    .exc_code_in(exc_code_in), .OPC(OPC), .in_delay_slot(in_delay_slot),
    .eret(eret), .cp0_wen(cp0_wen), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
    .cp0_rdata(cp0_rdata), .EXCCODE(EXCCODE), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .exl(exl),
    .exc_count(exc_count)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    logic r;
    r = Reset;
    @(posedge Clock);
    #1;
    edges = r ? edges + 1 : 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bounded wait for a redirect, then compare against the scoreboard head.
  task automatic expect_redirect(input string tag);
    logic [31:0] exp_pc;
    for (int n = 0; n < 4 && !redirect_valid; n++) tick();
    check({tag, "_redir_seen"}, 32'(redirect_valid), 32'd1);
    if (redirect_valid) begin
      exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      check({tag, "_redir_pc"}, redirect_pc, exp_pc);
      check({tag, "_redir_flush"}, 32'(flush), 32'd1);
    end
  endtask

  task automatic read_reg(input string tag, input logic [4:0] a,
                          input logic [31:0] mask, input logic [31:0] exp);
    cp0_addr = a;
    tick();
    check(tag, cp0_rdata & mask, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0_wen = 1'b1; cp0_addr = a; cp0_wdata = d;
    tick();
    cp0_wen = 1'b0;
  endtask

  task automatic exc_event(input string tag, input logic [4:0] code, input logic [31:0] pc,
                           input logic ds, input logic [15:0] exp_cnt);
    check({tag, "_ready"}, 32'(exc_ready), 32'd1);
    exc_valid = 1'b1; exc_code_in = code; OPC = pc; in_delay_slot = ds;
    exp_q.push_back(VEC);
    tick();
    exc_valid = 1'b0; in_delay_slot = 1'b0;
    check({tag, "_excode"}, 32'(EXCCODE), 32'(code));
    check({tag, "_flush_n1"}, 32'(flush), 32'd1);
    check({tag, "_noredir_n1"}, 32'(redirect_valid), 32'd0);
    check({tag, "_exl"}, 32'(exl), 32'd1);
    check({tag, "_count"}, 32'(exc_count), 32'(exp_cnt));
    tick();
    check({tag, "_excode_once"}, 32'(EXCCODE), 32'd0);
    expect_redirect(tag);
    tick();
    check({tag, "_idle_flush"}, 32'(flush), 32'd0);
  endtask

  task automatic eret_event(input string tag, input logic [31:0] exp_pc);
    eret = 1'b1;
    exp_q.push_back(exp_pc);
    tick();
    eret = 1'b0;
    check({tag, "_exl"}, 32'(exl), 32'd0);
    check({tag, "_excode"}, 32'(EXCCODE), 32'd0);
    check({tag, "_redir_n1"}, 32'(redirect_valid), 32'd1);
    expect_redirect(tag);
    tick();
    check({tag, "_ready"}, 32'(exc_ready), 32'd1);
  endtask

  initial begin
    Reset = 1'b0; exc_valid = 1'b0; exc_code_in = 5'd0; OPC = 32'd0;
    in_delay_slot = 1'b0; eret = 1'b0; cp0_wen = 1'b0; cp0_addr = 5'd0;
    cp0_wdata = 32'd0;
    tick();
    tick();
    check("rst_ready", 32'(exc_ready), 32'd1);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_redir", 32'(redirect_valid), 32'd0);
    check("rst_pc", redirect_pc, 32'd0);
    check("rst_excode", 32'(EXCCODE), 32'd0);
    check("rst_exl", 32'(exl), 32'd0);
    check("rst_count", 32'(exc_count), 32'd0);
    check("rst_rdata", cp0_rdata, 32'd0);
    Reset = 1'b1;

    // Timer interrupt: Count reaches 20 at edge 20, IP7 visible after it,
    // interrupt accepted on the following edge (Count becomes 22).
    mtc0(5'd12, 32'h0000_8001);
    cp0_wen = 1'b1; cp0_addr = 5'd11; cp0_wdata = 32'd20;
    tick();
    cp0_wen = 1'b0;
    check("cmp_fwd", cp0_rdata, 32'd20);
    read_reg("status_rd", 5'd12, 32'hFFFF_FFFF, 32'h0000_8001);
    exp_q.push_back(VEC);
    for (int i = 0; i < 40 && !flush; i++) tick();
    check("int_edge", 32'(edges), 32'd22);
    check("int_excode", 32'(EXCCODE), 32'd0);
    check("int_count", 32'(exc_count), 32'd1);
    check("int_exl", 32'(exl), 32'd1);
    expect_redirect("int");
    read_reg("int_cause", 5'd13, 32'hFFFF_FFFF, 32'h0000_8000);
    mtc0(5'd11, 32'd40);
    read_reg("ip7_clr", 5'd13, 32'hFFFF_FFFF, 32'h0000_0000);
    mtc0(5'd12, 32'h0000_0000);
    check("status_clr_exl", 32'(exl), 32'd0);

    // Syscall, then eret back to it.
    exc_event("sys", 5'h03, 32'h0040_0010, 1'b0, 16'd2);
    read_reg("sys_epc", 5'd14, 32'hFFFF_FFFF, 32'h0040_0010);
    eret_event("eret1", 32'h0040_0010);

    // Overflow in a delay slot.
    exc_event("ovf", 5'h0C, 32'h0040_0024, 1'b1, 16'd3);
    read_reg("ovf_epc", 5'd14, 32'hFFFF_FFFF, 32'h0040_0020);
    read_reg("ovf_cause", 5'd13, 32'h8000_007C, 32'h8000_0030);
    eret_event("eret2", 32'h0040_0020);

    // Nested: syscall, break held by the pipeline while not ready.
    exc_valid = 1'b1; exc_code_in = 5'h03; OPC = 32'h0040_0040;
    exp_q.push_back(VEC);
    tick();
    exc_code_in = 5'h01; OPC = 32'h0040_0050;
    exp_q.push_back(VEC);
    check("nest_ready_flush", 32'(exc_ready), 32'd0);
    expect_redirect("nest1");
    check("nest_ready_redir", 32'(exc_ready), 32'd0);
    tick();
    check("nest_ready_idle", 32'(exc_ready), 32'd1);
    tick();
    exc_valid = 1'b0;
    check("nest_excode", 32'(EXCCODE), 32'h01);
    check("nest_count", 32'(exc_count), 32'd5);
    tick();
    expect_redirect("nest2");
    tick();
    read_reg("nest_epc", 5'd14, 32'hFFFF_FFFF, 32'h0040_0040);
    read_reg("nest_cause", 5'd13, 32'h8000_007C, 32'h0000_0004);
    eret_event("eret3", 32'h0040_0040);

    // Collision: exception + eret + mtc0 EPC in one cycle.
    exc_valid = 1'b1; exc_code_in = 5'h03; OPC = 32'h0040_0100; eret = 1'b1;
    cp0_wen = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_1234;
    exp_q.push_back(VEC);
    tick();
    exc_valid = 1'b0; eret = 1'b0; cp0_wen = 1'b0;
    check("col_excode", 32'(EXCCODE), 32'h03);
    check("col_epc_fwd", cp0_rdata, 32'h0040_0100);
    check("col_count", 32'(exc_count), 32'd6);
    tick();
    expect_redirect("col");
    tick();
    check("col_no_eret", 32'(redirect_valid), 32'd0);
    check("col_idle", 32'(flush), 32'd0);
    read_reg("col_epc", 5'd14, 32'hFFFF_FFFF, 32'h0040_0100);

    // Reset in FLUSH aborts without redirect.
    exc_valid = 1'b1; exc_code_in = 5'h1F; OPC = 32'h0040_0200;
    tick();
    exc_valid = 1'b0;
    check("rf_flush", 32'(flush), 32'd1);
    check("rf_excode", 32'(EXCCODE), 32'h1F);
    Reset = 1'b0; cp0_addr = 5'd9;
    tick();
    check("rf_flush0", 32'(flush), 32'd0);
    check("rf_redir0", 32'(redirect_valid), 32'd0);
    check("rf_ready", 32'(exc_ready), 32'd1);
    check("rf_excode0", 32'(EXCCODE), 32'd0);
    check("rf_exl0", 32'(exl), 32'd0);
    check("rf_count0", 32'(exc_count), 32'd0);
    check("rf_rdata0", cp0_rdata, 32'd0);
    check("rf_pc0", redirect_pc, 32'd0);
    Reset = 1'b1;
    tick();
    check("rf_no_redir", 32'(redirect_valid), 32'd0);
    check("rf_count_restart", cp0_rdata, 32'd1);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_exception_unit.md
Name: cp0_exception_unit

Overview:
Producer side of the exception path. The register file consumes EXCCODE and OPC to report break, syscall, undefined and overflow events; this block generates them. It arbitrates exception and interrupt events from the MEM stage and maintains the CP0 Status, Cause, EPC, Count and Compare registers. It drives pipeline flush and PC redirect, serves mfc0/mtc0 accesses, and handles eret.

Parameters:
EXC_VECTOR, 32'h8000_0180, redirect target for every exception and interrupt
CNT_W, 16, width of the saturating exception-event counter

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  synchronous, active-low reset
exc_valid  in  1  MEM-stage instruction raises an exception
exc_ready  out  1  high only in IDLE; the event is accepted when exc_valid && exc_ready
exc_code_in  in  5  0x01 break, 0x03 syscall, 0x0C overflow, 0x1F undefined
OPC  in  32  PC of the MEM-stage instruction
in_delay_slot  in  1  MEM-stage instruction is in a branch delay slot
eret  in  1  MEM-stage instruction is eret; uses the same ready handshake
cp0_wen  in  1  mtc0 write enable
cp0_addr  in  5  CP0 register number for mtc0 or mfc0
cp0_wdata  in  32  mtc0 data
cp0_rdata  out  32  mfc0 data, registered
EXCCODE  out  5  code of the committed event, 0 otherwise
flush  out  1  kill IF through MEM
redirect_valid  out  1  one-cycle pulse
redirect_pc  out  32  redirect target
exl  out  1  Status.EXL
exc_count  out  CNT_W  count of accepted exceptions and interrupts, saturating

Behaviour:
Reset (Reset==0 at the clock edge, takes precedence over everything):
- Status, Cause, EPC, Count, Compare = 0.
- FSM = IDLE.
- All outputs = 0, except exc_ready = 1.
- Reset mid-sequence aborts the sequence with no redirect.

CP0 register map:
- 9 Count: increments every cycle, wraps at 2^32.
- 11 Compare: a write clears Cause.IP7.
- 12 Status: writable bits IE[0], EXL[1], IM[15:8]; all other bits read 0.
- 13 Cause: BD[31], IP7[15], software-writable IP[9:8], ExcCode[6:2].
- 14 EPC: fully writable.
- Any other address reads 0; writes to it are ignored.

Timer:
- When Count == Compare and Compare != 0, set IP7.
- An interrupt is pending when Status.IE && !EXL && |(Cause.IP & Status.IM).

FSM states: IDLE, FLUSH, REDIRECT, ERET_REDIR.
- IDLE, accepted exception, or pending interrupt (code 0x00):
  - Cause.ExcCode = code.
  - If EXL == 0: EPC = in_delay_slot ? OPC-4 : OPC, BD = in_delay_slot.
  - If EXL == 1 (nested): EPC and BD unchanged.
  - EXL = 1, exc_count++.
  - EXCCODE = code for exactly one cycle. For an interrupt it is 0x00, so nothing is printed.
  - Next state FLUSH.
- FLUSH: flush = 1 for 1 cycle, then REDIRECT.
- REDIRECT: redirect_valid = 1, redirect_pc = EXC_VECTOR, flush = 1, then IDLE.
- Latency: event accepted at edge N; flush high in cycle N+1; redirect in cycle N+2.
- IDLE, accepted eret: EXL = 0, then ERET_REDIR.
- ERET_REDIR: redirect_valid = 1, redirect_pc = EPC, flush = 1, then IDLE.

Priority within one cycle:
- Synchronous exception wins over eret, which wins over interrupt.
- A losing interrupt stays pending.
- An mtc0 in the same cycle as an accepted exception or eret is discarded.
- Events arriving outside IDLE see exc_ready = 0; the pipeline holds them.

mfc0 read:
- cp0_rdata registered, 1-cycle latency.
- A same-cycle mtc0 to the same address returns the new value.
- Count reads the post-increment value.

exc_count saturates at all-ones.

Decomposition:
- Shared package (header in the style of the existing Para.v):
  - CP0 register numbers 9/11/12/13/14.
  - Exception codes 0x00/0x01/0x03/0x0C/0x1F.
  - Status and Cause bit positions.
  - FSM state encodings.
- One natural sub-module, cp0_timer: Count/Compare, IP7 generation, and Compare-write clear.

Test Plan:
- Syscall: exc_valid=1, exc_code_in=0x03, OPC=0x0040_0010, in_delay_slot=0 → EXCCODE=0x03 for 1 cycle; EPC=0x0040_0010; EXL=1; flush high in cycle N+1; redirect_pc=0x8000_0180 in cycle N+2; exc_count=1.
- Delay-slot overflow: code 0x0C, OPC=0x0040_0024, in_delay_slot=1 → EPC=0x0040_0020, BD=1. Then eret → redirect_pc=0x0040_0020, EXL=0.
- Nested: break while EXL=1 → EPC unchanged, ExcCode=0x01, redirect to vector. exc_ready=0 during FLUSH/REDIRECT while the bench holds exc_valid; the held event is accepted on the next IDLE edge.
- Timer: mtc0 Status=0x0000_8001, mtc0 Compare=20 → interrupt taken when Count reaches 20, EXCCODE=0x00. mtc0 Compare=40 clears IP7.
- Collision: exception, eret and mtc0 EPC=0x1234 in the same cycle → exception taken; EPC=OPC, not 0x1234; eret ignored.
- Reset low during FLUSH → next cycle all outputs 0, no redirect_valid, exc_ready=1, Count restarts at 0.
